cla_seq_ctrl: RTL and testbench

Sequencing controller that performs WIDTH-bit addition by time-multiplexing one 4-bit carry-lookahead adder slice, one nibble per cycle, LSB first.
- Carry is chained through a register between cycles.
- Operands and result use valid/ready handshakes.
- Sits between the register-file/operand path and the 4-bit CLA datapath, so wide adds run without replicating adder hardware.

---
 rtl/cla_pkg.sv | 7 +
 rtl/cla_nibble.sv | 19 +
 rtl/cla_seq_ctrl.sv | 82 ++++++++
 tb/tb_cla_seq_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared FSM states, slice width and op encodings for the sequenced CLA adder
package cla_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE_W = 4;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/cla_nibble.sv
// cla_nibble: 4-bit carry-lookahead adder slice with explicit carry-in
module cla_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [3:1] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cin);
  assign s = p ^ {c, cin};
endmodule

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: WIDTH-bit add through one reused CLA nibble slice, LSB nibble first.
// Define CLA_SEQ_SUB_EN to enable subtraction when op=1.
module cla_seq_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
  state_t state, state_nxt;
  logic [IW-1:0] idx;
  logic carry, co_nib, last, cin0;
  logic [WIDTH-1:0] a_lat, b_lat, b_eff;
  logic [NIBBLE_W-1:0] s_nib;
`ifdef CLA_SEQ_SUB_EN
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign cin0  = (op == OP_SUB);
`else
  logic unused_op;
  assign unused_op = op;
  assign b_eff = b;
  assign cin0  = 1'b0;
`endif
  assign last = (idx == IW'(NIB - 1));
  cla_nibble u_nib (
    .a  (a_lat[idx*NIBBLE_W +: NIBBLE_W]),
    .b  (b_lat[idx*NIBBLE_W +: NIBBLE_W]),
    .cin(carry),
    .s  (s_nib),
    .co (co_nib)
  );
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    unique case (state)
      IDLE:    state_nxt = in_valid ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_lat <= '0;
      b_lat <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        a_lat <= a;
        b_lat <= b_eff;
        carry <= cin0;
        idx   <= '0;
      end
      if (state == RUN) begin
        sum[idx*NIBBLE_W +: NIBBLE_W] <= s_nib;
        carry <= co_nib;
        idx   <= last ? '0 : idx + 1'b1;
        if (last) cout <= co_nib;
      end
    end
  end
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl: table vectors, hand sequences and random ops against an arithmetic model
module tb_cla_seq_ctrl;
  localparam int W = 16;
  localparam int NIB = W / 4;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, op = 0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, busy;
  logic [W-1:0] sum;
  int vec = 0, miscmp = 0;

  cla_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic op;
    logic [W-1:0] es;
    logic ec;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
`ifdef CLA_SEQ_SUB_EN
    if (o) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
`endif
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".sum"}, 64'(sum), 64'd0);
    chk({tag, ".cout"}, 64'(cout), 64'd0);
  endtask

  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
    int g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    chk("accept_ready", 64'(in_ready), 64'd1);
    a = x; b = y; op = o; in_valid = 1;
    @(negedge clk);
    in_valid = 0; a = $urandom; b = $urandom; op = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    chk({tag, ".latency"}, 64'(cyc), 64'(NIB));
    chk({tag, ".in_ready_done"}, 64'(in_ready), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic o, input int hold, input logic early);
    logic [W:0] m;
    m = model(x, y, o);
    if (early) out_ready = 1;
    accept(x, y, o);
    wait_done(tag);
    chk({tag, ".sum"}, 64'(sum), 64'(m[W-1:0]));
    chk({tag, ".cout"}, 64'(cout), 64'(m[W]));
    if (!early) begin
      repeat (hold) @(negedge clk);
      out_ready = 1;
    end
    @(negedge clk);
    out_ready = 0;
    chk({tag, ".back_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] hs;
    logic hc;
    tbl.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0});
    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
    tbl.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1});
    tbl.push_back('{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0});
`ifdef CLA_SEQ_SUB_EN
    tbl.push_back('{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0});
    tbl.push_back('{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1});
    tbl.push_back('{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1});
`else
    tbl.push_back('{16'h0005, 16'h0007, 1'b1, 16'h000C, 1'b0});
`endif
    rst = 1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0;
    @(negedge clk);
    chk_reset_outputs("idle");

    foreach (tbl[i]) begin
      accept(tbl[i].a, tbl[i].b, tbl[i].op);
      wait_done($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.sum", i), 64'(sum), 64'(tbl[i].es));
      chk($sformatf("tbl%0d.cout", i), 64'(cout), 64'(tbl[i].ec));
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
    end

    accept(16'hABCD, 16'h1111, 1'b0);
    wait_done("bp");
    hs = sum; hc = cout;
    chk("bp.sum", 64'(hs), 64'h0000_0000_0000_BCDE);
    in_valid = 1; a = 16'h0101; b = 16'h0202; op = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp.hold_valid", 64'(out_valid), 64'd1);
      chk("bp.hold_sum", 64'(sum), 64'(hs));
      chk("bp.hold_cout", 64'(cout), 64'(hc));
      chk("bp.hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("bp.not_accepted_busy", 64'(busy), 64'd0);
    chk("bp.in_ready", 64'(in_ready), 64'd1);
    in_valid = 0;
    run_op("bp2", 16'h0101, 16'h0202, 1'b0, 0, 1'b0);

    accept(16'hFFFF, 16'hFFFF, 1'b0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_reset_outputs("midrun");
    run_op("after_rst", 16'h0001, 16'h0002, 1'b0, 0, 1'b0);
    chk("after_rst.sum_val", 64'(sum), 64'h3);

    for (int n = 0; n < 40; n++)
      run_op($sformatf("rnd%0d", n), W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
